// File: rtl/dsp_pipe_checker.sv
// Response-side checker for the pipelined p = (a*b) & c DSP block: tracks expected
// results through a latency-matched delay line and scores the DUT output p.
module dsp_pipe_checker #(
  parameter int WIDTH       = 16,
  parameter int LATENCY     = 2,
  parameter int NUM_VECTORS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      match_cnt,
  output logic [15:0]      mismatch_cnt,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic [15:0]      err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] NV = 16'(NUM_VECTORS);

  state_t             state;
  logic [LATENCY-1:0] dl_valid;
  logic [WIDTH-1:0]   dl_exp [LATENCY];
  logic [15:0]        dl_idx [LATENCY];
  logic [15:0]        issued;
  logic [WIDTH-1:0]   prod_lo;
  logic [WIDTH-1:0]   exp_in;
  logic               issue;
  logic               cmp;
  logic               hit;
  logic               drain_empty;
  logic [15:0]        match_nxt;
  logic [15:0]        mismatch_nxt;

  // Only the low WIDTH bits of the product survive, so a WIDTH-wide multiply suffices.
  assign prod_lo = a * b;
  assign exp_in  = prod_lo & c;

  // in_valid has no ready: a vector counts when in_valid is high in RUN with quota left.
  assign issue = in_valid && (state == RUN) && (issued < NV);
  assign cmp   = dl_valid[LATENCY-1];
  assign hit   = (p == dl_exp[LATENCY-1]);

  always_comb begin
    match_nxt    = match_cnt;
    mismatch_nxt = mismatch_cnt;
    if (cmp && hit && (match_cnt != 16'hFFFF))
      match_nxt = match_cnt + 16'd1;
    if (cmp && !hit && (mismatch_cnt != 16'hFFFF))
      mismatch_nxt = mismatch_cnt + 16'd1;
  end

  // The last stage may still be comparing on the DRAIN->DONE edge; its result lands in the same edge.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++)
      if (dl_valid[i]) drain_empty = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_exp[i] <= '0;
        dl_idx[i] <= '0;
      end
    end else begin
      dl_valid[0] <= issue;
      dl_exp[0]   <= exp_in;
      dl_idx[0]   <= issued;
      for (int i = 1; i < LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_exp[i]   <= dl_exp[i-1];
        dl_idx[i]   <= dl_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_exp      <= '0;
      err_got      <= '0;
      err_idx      <= '0;
      issued       <= '0;
    end else begin
      if ((state == RUN) || (state == DRAIN)) begin
        match_cnt    <= match_nxt;
        mismatch_cnt <= mismatch_nxt;
        if (cmp && !hit && (mismatch_cnt == 16'd0)) begin
          err_exp <= dl_exp[LATENCY-1];
          err_got <= p;
          err_idx <= dl_idx[LATENCY-1];
        end
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err_exp      <= '0;
            err_got      <= '0;
            err_idx      <= '0;
            issued       <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            issued <= issued + 16'd1;
            if ((issued + 16'd1) == NV)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_nxt == 16'd0) && (match_nxt == NV);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_pipe_checker.sv
// Bench for dsp_pipe_checker: a fake 2-cycle DSP drives p, runs are scored by a
// reference model into a queue, and a monitor checks each done against it.
module tb_dsp_pipe_checker;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         start2 = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic [W-1:0] got_in = '0;
  logic [W-1:0] dut_s1;
  logic [W-1:0] p;

  logic         busy, done, pass;
  logic [15:0]  match_cnt, mismatch_cnt, err_idx;
  logic [W-1:0] err_exp, err_got;
  logic         busy_2, done_2, pass_2;
  logic [15:0]  match_2, mismatch_2, err_idx_2;
  logic [W-1:0] err_exp_2, err_got_2;

  dsp_pipe_checker #(.WIDTH(W), .LATENCY(2), .NUM_VECTORS(4)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .p(p),
    .busy(busy), .done(done), .pass(pass),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .err_exp(err_exp), .err_got(err_got), .err_idx(err_idx)
  );

  dsp_pipe_checker #(.WIDTH(W), .LATENCY(3), .NUM_VECTORS(4)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .p(p),
    .busy(busy_2), .done(done_2), .pass(pass_2),
    .match_cnt(match_2), .mismatch_cnt(mismatch_2),
    .err_exp(err_exp_2), .err_got(err_got_2), .err_idx(err_idx_2)
  );

  // clock / reset-free timing base
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle stand-in for the DSP block; got_in is what the "DUT" will answer.
  always @(posedge clk) begin
    dut_s1 <= got_in;
    p      <= dut_s1;
  end

  typedef struct {
    logic [15:0] m;
    logic [15:0] mm;
    logic        ps;
    logic [15:0] ee;
    logic [15:0] eg;
    logic [15:0] ei;
    int          dcyc;
  } res_t;

  res_t exp_q[$];
  res_t mr;
  int   total = 0;
  int   bad = 0;
  logic [15:0] last_m;

  logic [15:0] va[4], vb[4], vc[4], vg[4];
  bit          pat_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  function automatic logic [15:0] ideal(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    logic [31:0] pr;
    pr = 32'(x) * 32'(y);
    return pr[15:0] & z;
  endfunction

  // driver tasks
  task automatic tick(input logic s, input logic v, input logic [15:0] xa,
                      input logic [15:0] xb, input logic [15:0] xc, input logic [15:0] xg);
    start    = s;
    in_valid = v;
    a        = xa;
    b        = xb;
    c        = xc;
    got_in   = xg;
    @(negedge clk);
  endtask

  task automatic tick_junk(input logic v);
    tick(1'b0, v, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic do_run(input bit abort, input int start_mid);
    int   k;
    int   e;
    res_t r;
    tick(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    k = 0;
    foreach (pat_q[i]) begin
      if (pat_q[i] && k < 4) begin
        e = cyc + 1;
        tick(i == start_mid, 1'b1, va[k], vb[k], vc[k], vg[k]);
        k++;
        if (k == 4 && !abort) begin
          r = '{m: 16'd0, mm: 16'd0, ps: 1'b0, ee: 16'd0, eg: 16'd0, ei: 16'd0, dcyc: e + 2};
          for (int j = 0; j < 4; j++) begin
            if (vg[j] == ideal(va[j], vb[j], vc[j])) r.m++;
            else begin
              if (r.mm == 0) begin
                r.ee = ideal(va[j], vb[j], vc[j]);
                r.eg = vg[j];
                r.ei = 16'(j);
              end
              r.mm++;
            end
          end
          r.ps = (r.mm == 0) && (r.m == 4);
          last_m = r.m;
          exp_q.push_back(r);
        end
      end else begin
        tick(i == start_mid, pat_q[i], 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom));
      end
    end
  endtask

  task automatic wait_done_and_hold;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick_junk(1'b0);
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) tick_junk(1'b1);
    chk("hold_done", done, 1);
    chk("hold_match", match_cnt, last_m);
    chk("hold_busy", busy, 0);
  endtask

  task automatic set_pattern(input int len, input logic [15:0] bits);
    pat_q.delete();
    for (int i = 0; i < len; i++) pat_q.push_back(bits[len-1-i]);
  endtask

  task automatic set_directed;
    va = '{16'd3, 16'hFFFF, 16'h0100, 16'd7};
    vb = '{16'd5, 16'hFFFF, 16'h0100, 16'd9};
    vc = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h000F};
    for (int j = 0; j < 4; j++) vg[j] = ideal(va[j], vb[j], vc[j]);
  endtask

  // scoreboard monitor
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n && done && !done_q) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mr = exp_q.pop_front();
        chk("match_cnt", match_cnt, mr.m);
        chk("mismatch_cnt", mismatch_cnt, mr.mm);
        chk("pass", pass, mr.ps);
        chk("err_exp", err_exp, mr.ee);
        chk("err_got", err_got, mr.eg);
        chk("err_idx", err_idx, mr.ei);
        chk("done_cycle", cyc, mr.dcyc);
      end
    end
    done_q <= done;
  end

  initial begin
    int ones;
    int done2_cyc;
    int e3;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_mismatch", mismatch_cnt, 0);
    chk("rst_err_idx", err_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid while IDLE must not issue anything
    repeat (3) tick_junk(1'b1);
    chk("idle_busy", busy, 0);
    chk("idle_match", match_cnt, 0);

    // ideal DUT, contiguous stream
    set_directed();
    set_pattern(4, 16'b1111);
    do_run(1'b0, -1);
    wait_done_and_hold();

    // DUT answers 0 on vector 1
    set_directed();
    vg[1] = 16'h0000;
    set_pattern(4, 16'b1111);
    do_run(1'b0, -1);
    wait_done_and_hold();

    // gaps, then two extra in_valid pulses while draining
    set_directed();
    set_pattern(9, 16'b101100111);
    do_run(1'b0, -1);
    wait_done_and_hold();

    // start pulse in the middle of RUN is ignored
    set_directed();
    set_pattern(6, 16'b101101);
    do_run(1'b0, 1);
    wait_done_and_hold();

    // reset in DRAIN abandons the run
    set_directed();
    set_pattern(4, 16'b1111);
    do_run(1'b1, -1);
    rst_n = 1'b0;
    #1;
    chk("drain_rst_busy", busy, 0);
    chk("drain_rst_match", match_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("drain_rst_done", done, 0);
    chk("drain_rst_mismatch", mismatch_cnt, 0);
    repeat (4) tick_junk(1'b0);
    chk("drain_rst_no_done", done, 0);
    set_pattern(5, 16'b11011);
    do_run(1'b0, -1);
    wait_done_and_hold();

    // randomized runs with random gaps and corrupted results
    for (int run = 0; run < 20; run++) begin
      for (int j = 0; j < 4; j++) begin
        va[j] = 16'($urandom);
        vb[j] = 16'($urandom);
        vc[j] = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
        vg[j] = ideal(va[j], vb[j], vc[j]);
        if ($urandom_range(0, 3) == 0) vg[j] = vg[j] ^ 16'($urandom_range(1, 65535));
      end
      pat_q.delete();
      ones = 0;
      while (ones < 4) begin
        pat_q.push_back($urandom_range(0, 2) != 0);
        if (pat_q[pat_q.size()-1]) ones++;
      end
      repeat ($urandom_range(0, 2)) pat_q.push_back($urandom_range(0, 1) == 1);
      do_run(1'b0, $urandom_range(0, pat_q.size() - 1));
      wait_done_and_hold();
    end

    // LATENCY=3 checker watching a 2-cycle DUT with a counting a
    start2 = 1'b1;
    tick_junk(1'b0);
    start2 = 1'b0;
    e3 = 0;
    for (int k = 0; k < 4; k++) begin
      e3 = cyc + 1;
      tick(1'b0, 1'b1, 16'(k), 16'd1, 16'hFFFF, 16'(k));
    end
    done2_cyc = -1;
    for (int k = 4; k < 14; k++) begin
      tick(1'b0, 1'b0, 16'(k), 16'd1, 16'hFFFF, 16'(k));
      if (done_2 && done2_cyc < 0) done2_cyc = cyc;
    end
    chk("lat3_done_cycle", done2_cyc, e3 + 3);
    chk("lat3_match", match_2, 0);
    chk("lat3_mismatch", mismatch_2, 4);
    chk("lat3_pass", pass_2, 0);
    chk("lat3_err_idx", err_idx_2, 0);
    chk("lat3_err_exp", err_exp_2, 0);
    chk("lat3_err_got", err_got_2, 1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
